pattern_checker: RTL

Serial receive-side checker for the 7-bit repeating test pattern driven by the pattern generator on the optical link model. It takes the recovered bit stream, searches for the pattern phase, verifies and declares lock, then counts bit errors and received bits for BER measurement. It sits at the receiver output of the channel model, paired with the generator at the transmit end.

---
 rtl/pattern_checker.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pattern_checker.sv
// Receive-side checker for a repeating 7-bit test pattern.
// Searches for the pattern phase, verifies it, then counts bits and bit errors.
module pattern_checker #(
    parameter int VERIFY_BITS = 14,
    parameter int LOSS_THRESH = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       pattern,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             clr,
    output logic             locked,
    output logic             bit_err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } state_e;

    state_e           state_q, state_d;
    logic [6:0]       hist_q, hist_d;
    logic [2:0]       fill_q, fill_d;
    logic [2:0]       phase_q, phase_d;
    logic [7:0]       vcnt_q, vcnt_d;
    logic [3:0]       cerr_q, cerr_d;
    logic             locked_q, locked_d;
    logic             bit_err_q, bit_err_d;
    logic [CNT_W-1:0] errc_q, errc_d;
    logic [CNT_W-1:0] bitc_q, bitc_d;

    logic [6:0] cand;
    logic [6:0] hit;
    logic [2:0] ph_hit;
    logic [2:0] phase_inc;
    logic       mism;

    assign cand = {hist_q[5:0], in_bit};

    // hit[k]: the window ends on pattern[k], so the next bit is pattern[k+1].
    for (genvar gk = 0; gk < 7; gk++) begin : g_rot
        logic [6:0] ev;
        for (genvar gj = 0; gj < 7; gj++) begin : g_bit
            assign ev[gj] = pattern[(gk - gj + 7) % 7];
        end
        assign hit[gk] = (cand == ev);
    end

    always_comb begin
        if (hit[0])      ph_hit = 3'd1;
        else if (hit[1]) ph_hit = 3'd2;
        else if (hit[2]) ph_hit = 3'd3;
        else if (hit[3]) ph_hit = 3'd4;
        else if (hit[4]) ph_hit = 3'd5;
        else if (hit[5]) ph_hit = 3'd6;
        else             ph_hit = 3'd0;
    end

    assign phase_inc = (phase_q == 3'd6) ? 3'd0 : phase_q + 3'd1;
    assign mism      = in_bit ^ pattern[phase_q];

    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        phase_d   = phase_q;
        vcnt_d    = vcnt_q;
        cerr_d    = cerr_q;
        errc_d    = errc_q;
        bitc_d    = bitc_q;
        bit_err_d = 1'b0;

        if (in_valid) begin
            hist_d = cand;
            fill_d = (fill_q == 3'd7) ? fill_q : fill_q + 3'd1;
            unique case (state_q)
                SEARCH: begin
                    if (fill_q >= 3'd6 && |hit) begin
                        phase_d = ph_hit;
                        vcnt_d  = 8'd0;
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    if (!mism) begin
                        vcnt_d  = vcnt_q + 8'd1;
                        phase_d = phase_inc;
                        if (vcnt_q + 8'd1 == 8'(VERIFY_BITS)) begin
                            state_d = LOCKED;
                            cerr_d  = 4'd0;
                        end
                    end else begin
                        state_d = SEARCH;
                    end
                end
                LOCKED: begin
                    phase_d = phase_inc;
                    if (bitc_q != '1) bitc_d = bitc_q + 1'b1;
                    if (mism) begin
                        bit_err_d = 1'b1;
                        if (errc_q != '1) errc_d = errc_q + 1'b1;
                        cerr_d = cerr_q + 4'd1;
                        if (cerr_q + 4'd1 == 4'(LOSS_THRESH)) begin
                            state_d = SEARCH;
                            cerr_d  = 4'd0;
                        end
                    end else begin
                        cerr_d = 4'd0;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        // clr wins over any count made on the same edge.
        if (clr) begin
            errc_d = '0;
            bitc_d = '0;
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SEARCH;
            hist_q    <= '0;
            fill_q    <= '0;
            phase_q   <= '0;
            vcnt_q    <= '0;
            cerr_q    <= '0;
            locked_q  <= 1'b0;
            bit_err_q <= 1'b0;
            errc_q    <= '0;
            bitc_q    <= '0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            phase_q   <= phase_d;
            vcnt_q    <= vcnt_d;
            cerr_q    <= cerr_d;
            locked_q  <= locked_d;
            bit_err_q <= bit_err_d;
            errc_q    <= errc_d;
            bitc_q    <= bitc_d;
        end
    end

    assign locked    = locked_q;
    assign bit_err   = bit_err_q;
    assign err_count = errc_q;
    assign bit_count = bitc_q;

endmodule
